// File: rtl/rs_pkg.sv
// Shared types for the reservation-station issue queue: operand and packet
// structs, default widths, and the CDB operand wakeup helper.
package rs_pkg;

    localparam int RS_TAG_W  = 6;
    localparam int RS_DATA_W = 64;
    localparam int RS_OP_W   = 5;

    typedef struct packed {
        logic [RS_TAG_W-1:0]  tag;
        logic                 ready;
        logic [RS_DATA_W-1:0] value;
    } rs_src_t;

    typedef struct packed {
        logic [RS_OP_W-1:0]  opcode;
        logic [RS_TAG_W-1:0] dest_tag;
        rs_src_t             src1;
        rs_src_t             src2;
    } rs_pkt_t;

    // Lane 1 is applied last so it wins when both lanes carry the same tag.
    function automatic rs_src_t rs_wake_src(
        input rs_src_t                        s,
        input logic [1:0]                     cv,
        input logic [1:0][RS_TAG_W-1:0]       ct,
        input logic [1:0][RS_DATA_W-1:0]      cval
    );
        rs_src_t r;
        r = s;
        for (int l = 0; l < 2; l++) begin
            if (!s.ready && cv[l] && (ct[l] == s.tag)) begin
                r.ready = 1'b1;
                r.value = cval[l];
            end
        end
        return r;
    endfunction

    function automatic rs_pkt_t rs_wake_pkt(
        input rs_pkt_t                        p,
        input logic [1:0]                     cv,
        input logic [1:0][RS_TAG_W-1:0]       ct,
        input logic [1:0][RS_DATA_W-1:0]      cval
    );
        rs_pkt_t r;
        r      = p;
        r.src1 = rs_wake_src(p.src1, cv, ct, cval);
        r.src2 = rs_wake_src(p.src2, cv, ct, cval);
        return r;
    endfunction

endpackage

// File: rtl/rs_issue_queue_sel2.sv
// Two-grant priority selector: lowest-index request and highest-index request
// distinct from it.
module rs_issue_queue_sel2 #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          lo_valid,
    output logic [IW-1:0] lo_idx,
    output logic          hi_valid,
    output logic [IW-1:0] hi_idx
);

    always_comb begin
        lo_valid = 1'b0;
        lo_idx   = '0;
        hi_valid = 1'b0;
        hi_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_valid = 1'b1;
                lo_idx   = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req[i] && (IW'(i) != lo_idx)) begin
                hi_valid = 1'b1;
                hi_idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rs_issue_queue.sv
// Dual-dispatch, dual-issue reservation station with CDB wakeup.
// Optional macro RS_WAKEUP_BYPASS_EN: entries woken by the CDB may issue in the same cycle.
module rs_issue_queue
    import rs_pkg::*;
#(
    parameter int RS_SIZE = 16,
    parameter int TAG_W   = RS_TAG_W,
    parameter int DATA_W  = RS_DATA_W,
    parameter int OP_W    = RS_OP_W
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic [1:0]                   disp_valid,
    input  rs_pkt_t [1:0]                disp_pkt,
    output logic                         disp_stall,
    output logic [$clog2(RS_SIZE):0]     free_cnt,
    input  logic [1:0]                   cdb_valid,
    input  logic [1:0][TAG_W-1:0]        cdb_tag,
    input  logic [1:0][DATA_W-1:0]       cdb_value,
    input  logic [1:0]                   fu_ready,
    output logic [1:0]                   iss_valid,
    output rs_pkt_t [1:0]                iss_pkt
);

    localparam int IW = $clog2(RS_SIZE);
    localparam int CW = IW + 1;

    // Packet layout is fixed by rs_pkg, so width overrides must agree with it.
    generate
        if (TAG_W != RS_TAG_W || DATA_W != RS_DATA_W || OP_W != RS_OP_W) begin : g_param_mismatch
            $error("rs_issue_queue: TAG_W/DATA_W/OP_W must match rs_pkg widths");
        end
    endgenerate

    logic [RS_SIZE-1:0] busy_q, busy_d;
    rs_pkt_t            ent_q [RS_SIZE];
    rs_pkt_t            ent_d [RS_SIZE];
    rs_pkt_t            woke  [RS_SIZE];
    logic [RS_SIZE-1:0] ent_rdy;
    rs_pkt_t            disp_woke [2];
    logic [CW-1:0]      busy_cnt;
    logic [1:0]         disp_en;

    logic               alloc_lo_v, alloc_hi_v, iss_lo_v, iss_hi_v;
    logic [IW-1:0]      alloc_lo_idx, alloc_hi_idx, iss_lo_idx, iss_hi_idx;

    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_ent
            assign woke[gi] = rs_wake_pkt(ent_q[gi], cdb_valid, cdb_tag, cdb_value);
`ifdef RS_WAKEUP_BYPASS_EN
            assign ent_rdy[gi] = busy_q[gi] & woke[gi].src1.ready & woke[gi].src2.ready;
`else
            assign ent_rdy[gi] = busy_q[gi] & ent_q[gi].src1.ready & ent_q[gi].src2.ready;
`endif
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign disp_woke[gi] = rs_wake_pkt(disp_pkt[gi], cdb_valid, cdb_tag, cdb_value);
        end
    endgenerate

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_cnt = busy_cnt + CW'(busy_q[i]);
        end
    end

    assign free_cnt   = CW'(RS_SIZE) - busy_cnt;
    assign disp_stall = (free_cnt < CW'(2));

    rs_issue_queue_sel2 #(.N(RS_SIZE)) u_alloc_sel (
        .req      (~busy_q),
        .lo_valid (alloc_lo_v),
        .lo_idx   (alloc_lo_idx),
        .hi_valid (alloc_hi_v),
        .hi_idx   (alloc_hi_idx)
    );

    rs_issue_queue_sel2 #(.N(RS_SIZE)) u_issue_sel (
        .req      (ent_rdy),
        .lo_valid (iss_lo_v),
        .lo_idx   (iss_lo_idx),
        .hi_valid (iss_hi_v),
        .hi_idx   (iss_hi_idx)
    );

    assign disp_en[0] = disp_valid[0] & alloc_lo_v & ~disp_stall & ~flush;
    assign disp_en[1] = disp_valid[1] & alloc_hi_v & ~disp_stall & ~flush;

    assign iss_valid[0] = iss_lo_v & fu_ready[0] & ~flush;
    assign iss_valid[1] = iss_hi_v & fu_ready[1] & ~flush;

`ifdef RS_WAKEUP_BYPASS_EN
    assign iss_pkt[0] = woke[iss_lo_idx];
    assign iss_pkt[1] = woke[iss_hi_idx];
`else
    assign iss_pkt[0] = ent_q[iss_lo_idx];
    assign iss_pkt[1] = ent_q[iss_hi_idx];
`endif

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = woke[i];
        end
        if (iss_valid[0]) busy_d[iss_lo_idx] = 1'b0;
        if (iss_valid[1]) busy_d[iss_hi_idx] = 1'b0;
        // Allocation uses registered busy, so issued slots reopen a cycle later.
        if (disp_en[0]) begin
            busy_d[alloc_lo_idx] = 1'b1;
            ent_d[alloc_lo_idx]  = disp_woke[0];
        end
        if (disp_en[1]) begin
            busy_d[alloc_hi_idx] = 1'b1;
            ent_d[alloc_hi_idx]  = disp_woke[1];
        end
        if (flush) busy_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            ent_q  <= ent_d;
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Self-checking bench for rs_issue_queue: directed scenarios plus a randomized
// run compared against a per-entry behavioural model.
module tb_rs_issue_queue;
    import rs_pkg::*;

    localparam int N = 16;

    logic              clock;
    logic              reset_n;
    logic              flush;
    logic [1:0]        disp_valid;
    rs_pkt_t [1:0]     disp_pkt;
    logic              disp_stall;
    logic [4:0]        free_cnt;
    logic [1:0]        cdb_valid;
    logic [1:0][5:0]   cdb_tag;
    logic [1:0][63:0]  cdb_value;
    logic [1:0]        fu_ready;
    logic [1:0]        iss_valid;
    rs_pkt_t [1:0]     iss_pkt;

    int checks = 0;
    int errors = 0;

    rs_issue_queue #(.RS_SIZE(N)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_pkt   (disp_pkt),
        .disp_stall (disp_stall),
        .free_cnt   (free_cnt),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .fu_ready   (fu_ready),
        .iss_valid  (iss_valid),
        .iss_pkt    (iss_pkt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic rs_src_t mk_src(input logic [5:0] t, input logic r, input logic [63:0] v);
        rs_src_t s;
        s.tag = t; s.ready = r; s.value = v;
        return s;
    endfunction

    function automatic rs_pkt_t mk_pkt(input logic [4:0] op, input logic [5:0] d,
                                       input rs_src_t s1, input rs_src_t s2);
        rs_pkt_t p;
        p.opcode = op; p.dest_tag = d; p.src1 = s1; p.src2 = s2;
        return p;
    endfunction

    task automatic idle();
        flush = 1'b0; disp_valid = 2'b00; disp_pkt = '0;
        cdb_valid = 2'b00; cdb_tag = '0; cdb_value = '0; fu_ready = 2'b00;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        disp_valid = 2'b11;
        disp_pkt[0] = mk_pkt(5'd1, 6'd1, mk_src(6'd0, 1'b1, 64'h1), mk_src(6'd0, 1'b1, 64'h2));
        disp_pkt[1] = disp_pkt[0];
        fu_ready = 2'b11;
        #2;
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL reset_free_cnt got %0d want 16", free_cnt); end
        checks++; if (disp_stall !== 1'b0) begin errors++; $display("FAIL reset_disp_stall got %b want 0", disp_stall); end
        checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL reset_iss_valid got %b want 00", iss_valid); end
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL reset_hold_free_cnt got %0d want 16", free_cnt); end
        idle();
        reset_n = 1'b1;
        tick();
        @(negedge clock);
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL reset_release_free_cnt got %0d want 16", free_cnt); end
        tick();
    endtask

    task automatic test_dual_dispatch();
        rs_pkt_t p0, p1;
        p0 = mk_pkt(5'd1, 6'd10, mk_src(6'd1, 1'b1, 64'h100), mk_src(6'd2, 1'b1, 64'h200));
        p1 = mk_pkt(5'd2, 6'd11, mk_src(6'd3, 1'b1, 64'h300), mk_src(6'd4, 1'b1, 64'h400));
        idle();
        disp_valid = 2'b11; disp_pkt[0] = p0; disp_pkt[1] = p1; fu_ready = 2'b11;
        @(negedge clock);
        checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL dual_same_cycle_issue got %b want 00", iss_valid); end
        tick();
        disp_valid = 2'b00;
        @(negedge clock);
        checks++; if (free_cnt !== 5'd14) begin errors++; $display("FAIL dual_free_cnt got %0d want 14", free_cnt); end
        checks++; if (iss_valid !== 2'b11) begin errors++; $display("FAIL dual_iss_valid got %b want 11", iss_valid); end
        checks++; if (iss_pkt[0] !== p0) begin errors++; $display("FAIL dual_port0_pkt got %h want %h", iss_pkt[0], p0); end
        checks++; if (iss_pkt[1] !== p1) begin errors++; $display("FAIL dual_port1_pkt got %h want %h", iss_pkt[1], p1); end
        tick();
        @(negedge clock);
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL dual_free_return got %0d want 16", free_cnt); end
        checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL dual_iss_after got %b want 00", iss_valid); end
        tick();
    endtask

    task automatic test_stall();
        idle();
        for (int k = 0; k < 8; k++) begin
            disp_valid = (k == 7) ? 2'b01 : 2'b11;
            disp_pkt[0] = mk_pkt(5'(k), 6'd20, mk_src(6'd60, 1'b0, 64'h0), mk_src(6'd0, 1'b1, 64'h5));
            disp_pkt[1] = mk_pkt(5'(k + 8), 6'd21, mk_src(6'd60, 1'b0, 64'h0), mk_src(6'd0, 1'b1, 64'h6));
            tick();
        end
        disp_valid = 2'b11;
        disp_pkt[0] = mk_pkt(5'd30, 6'd1, mk_src(6'd0, 1'b1, 64'h1), mk_src(6'd0, 1'b1, 64'h1));
        disp_pkt[1] = disp_pkt[0];
        @(negedge clock);
        checks++; if (free_cnt !== 5'd1) begin errors++; $display("FAIL stall_free_cnt got %0d want 1", free_cnt); end
        checks++; if (disp_stall !== 1'b1) begin errors++; $display("FAIL stall_flag got %b want 1", disp_stall); end
        tick();
        disp_valid = 2'b00;
        @(negedge clock);
        checks++; if (free_cnt !== 5'd1) begin errors++; $display("FAIL stall_ignored_free_cnt got %0d want 1", free_cnt); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clock);
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL stall_flush_free_cnt got %0d want 16", free_cnt); end
        tick();
    endtask

    task automatic test_wakeup();
        idle();
        fu_ready = 2'b11;
        disp_valid = 2'b01;
        disp_pkt[0] = mk_pkt(5'd3, 6'd12, mk_src(6'd5, 1'b0, 64'h0), mk_src(6'd9, 1'b1, 64'h99));
        tick();
        disp_valid = 2'b00;
        cdb_valid = 2'b01; cdb_tag[0] = 6'd5; cdb_value[0] = 64'hAB;
        @(negedge clock);
`ifdef RS_WAKEUP_BYPASS_EN
        checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL wake_bypass_valid got %b want 01", iss_valid); end
        checks++; if (iss_pkt[0].src1.value !== 64'hAB) begin errors++; $display("FAIL wake_bypass_value got %h want ab", iss_pkt[0].src1.value); end
        tick();
        idle(); fu_ready = 2'b11;
        @(negedge clock);
        checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL wake_bypass_after got %b want 00", iss_valid); end
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL wake_bypass_free got %0d want 16", free_cnt); end
`else
        checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL wake_same_cycle got %b want 00", iss_valid); end
        tick();
        idle(); fu_ready = 2'b11;
        @(negedge clock);
        checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL wake_next_valid got %b want 01", iss_valid); end
        checks++; if (iss_pkt[0].src1.value !== 64'hAB) begin errors++; $display("FAIL wake_next_value got %h want ab", iss_pkt[0].src1.value); end
        tick();
        @(negedge clock);
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL wake_free got %0d want 16", free_cnt); end
`endif
        tick();
        idle();
        disp_valid = 2'b01;
        disp_pkt[0] = mk_pkt(5'd4, 6'd13, mk_src(6'd5, 1'b0, 64'h0), mk_src(6'd9, 1'b1, 64'h99));
        tick();
        disp_valid = 2'b00;
        cdb_valid = 2'b11; cdb_tag[0] = 6'd5; cdb_tag[1] = 6'd5;
        cdb_value[0] = 64'h11; cdb_value[1] = 64'h22;
        tick();
        idle(); fu_ready = 2'b11;
        @(negedge clock);
        checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL wake_lane1_valid got %b want 01", iss_valid); end
        checks++; if (iss_pkt[0].src1.value !== 64'h22) begin errors++; $display("FAIL wake_lane1_wins got %h want 22", iss_pkt[0].src1.value); end
        tick();
    endtask

    task automatic test_dispatch_capture();
        idle();
        fu_ready = 2'b11;
        disp_valid = 2'b01;
        disp_pkt[0] = mk_pkt(5'd6, 6'd14, mk_src(6'd1, 1'b1, 64'h1), mk_src(6'd7, 1'b0, 64'h0));
        cdb_valid = 2'b10; cdb_tag[1] = 6'd7; cdb_value[1] = 64'h77;
        @(negedge clock);
        checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL capture_same_cycle got %b want 00", iss_valid); end
        tick();
        idle(); fu_ready = 2'b11;
        @(negedge clock);
        checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL capture_issue got %b want 01", iss_valid); end
        checks++; if (iss_pkt[0].src2.value !== 64'h77 || iss_pkt[0].src2.ready !== 1'b1)
            begin errors++; $display("FAIL capture_value got %h/%b want 77/1", iss_pkt[0].src2.value, iss_pkt[0].src2.ready); end
        tick();
    endtask

    task automatic test_flush();
        idle();
        disp_valid = 2'b11;
        disp_pkt[0] = mk_pkt(5'd7, 6'd1, mk_src(6'd0, 1'b1, 64'h1), mk_src(6'd0, 1'b1, 64'h2));
        disp_pkt[1] = disp_pkt[0];
        tick(); tick();
        fu_ready = 2'b11; flush = 1'b1;
        @(negedge clock);
        checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL flush_iss_valid got %b want 00", iss_valid); end
        checks++; if (free_cnt !== 5'd12) begin errors++; $display("FAIL flush_pre_free got %0d want 12", free_cnt); end
        tick();
        idle(); fu_ready = 2'b11;
        @(negedge clock);
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL flush_free_cnt got %0d want 16", free_cnt); end
        checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL flush_after_iss got %b want 00", iss_valid); end
        tick();
    endtask

    task automatic test_port_independence();
        idle();
        // Pair k lands in entries k and 15-k: entry 2 is lane 0 of pair 2, entry 9 lane 1 of pair 6.
        for (int k = 0; k < 7; k++) begin
            disp_valid = 2'b11;
            disp_pkt[0] = mk_pkt(5'(k), 6'd2, mk_src(6'd60, (k == 2), 64'h0), mk_src(6'd0, 1'b1, 64'h3));
            disp_pkt[1] = mk_pkt(5'(16 + k), 6'd3, mk_src(6'd60, (k == 6), 64'h0), mk_src(6'd0, 1'b1, 64'h4));
            tick();
        end
        disp_valid = 2'b00;
        fu_ready = 2'b10;
        @(negedge clock);
        checks++; if (iss_valid !== 2'b10) begin errors++; $display("FAIL port1_only_valid got %b want 10", iss_valid); end
        checks++; if (iss_pkt[1].opcode !== 5'd22) begin errors++; $display("FAIL port1_entry9 got op %0d want 22", iss_pkt[1].opcode); end
        tick();
        fu_ready = 2'b00;
        @(negedge clock);
        checks++; if (free_cnt !== 5'd3) begin errors++; $display("FAIL port1_free_cnt got %0d want 3", free_cnt); end
        tick();
        fu_ready = 2'b01;
        @(negedge clock);
        checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL entry2_kept_valid got %b want 01", iss_valid); end
        checks++; if (iss_pkt[0].opcode !== 5'd2) begin errors++; $display("FAIL entry2_kept_op got %0d want 2", iss_pkt[0].opcode); end
        tick();
        idle(); flush = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        disp_valid = 2'b11;
        disp_pkt[0] = mk_pkt(5'd9, 6'd1, mk_src(6'd0, 1'b1, 64'h1), mk_src(6'd0, 1'b1, 64'h2));
        disp_pkt[1] = disp_pkt[0];
        tick();
        idle(); fu_ready = 2'b11;
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL midreset_iss_valid got %b want 00", iss_valid); end
        checks++; if (free_cnt !== 5'd16) begin errors++; $display("FAIL midreset_free_cnt got %0d want 16", free_cnt); end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        @(negedge clock);
        checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL midreset_after_iss got %b want 00", iss_valid); end
        tick();
    endtask

    // Reference model: a list of slots, each either empty or holding a packet.
    bit      m_busy [N];
    rs_pkt_t m_pkt  [N];

    function automatic rs_src_t m_wake(input rs_src_t s);
        rs_src_t r;
        r = s;
        if (!s.ready) begin
            if (cdb_valid[1] && cdb_tag[1] == s.tag) begin
                r.ready = 1'b1; r.value = cdb_value[1];
            end else if (cdb_valid[0] && cdb_tag[0] == s.tag) begin
                r.ready = 1'b1; r.value = cdb_value[0];
            end
        end
        return r;
    endfunction

    function automatic rs_pkt_t m_wake_pkt(input rs_pkt_t p);
        rs_pkt_t r;
        r = p;
        r.src1 = m_wake(p.src1);
        r.src2 = m_wake(p.src2);
        return r;
    endfunction

    task automatic test_random();
        int      nfree;
        int      rq[$];
        bit      ev0, ev1;
        int      ix0, ix1;
        rs_pkt_t view [N];
        rs_pkt_t nxt  [N];
        bit      nb   [N];
        idle(); flush = 1'b1;
        tick();
        idle();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0; m_pkt[i] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            disp_valid = 2'($urandom_range(0, 3));
            for (int l = 0; l < 2; l++) begin
                disp_pkt[l] = mk_pkt(5'($urandom), 6'($urandom),
                    mk_src(6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), {$urandom, $urandom}),
                    mk_src(6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), {$urandom, $urandom}));
                cdb_tag[l]   = 6'($urandom_range(0, 7));
                cdb_value[l] = {$urandom, $urandom};
            end
            cdb_valid = 2'($urandom_range(0, 3));
            fu_ready  = 2'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 39) == 0);

            nfree = 0;
            rq.delete();
            for (int i = 0; i < N; i++) begin
                if (!m_busy[i]) nfree++;
`ifdef RS_WAKEUP_BYPASS_EN
                view[i] = m_wake_pkt(m_pkt[i]);
`else
                view[i] = m_pkt[i];
`endif
                if (m_busy[i] && view[i].src1.ready && view[i].src2.ready) rq.push_back(i);
            end
            ev0 = (rq.size() >= 1) && fu_ready[0] && !flush;
            ev1 = (rq.size() >= 2) && fu_ready[1] && !flush;
            ix0 = (rq.size() >= 1) ? rq[0] : 0;
            ix1 = (rq.size() >= 2) ? rq[rq.size() - 1] : 0;

            @(negedge clock);
            checks++; if (free_cnt !== 5'(nfree)) begin errors++; $display("FAIL rand_free_cnt cyc %0d got %0d want %0d", cyc, free_cnt, nfree); end
            checks++; if (disp_stall !== (nfree < 2)) begin errors++; $display("FAIL rand_stall cyc %0d got %b want %b", cyc, disp_stall, (nfree < 2)); end
            checks++; if (iss_valid !== {ev1, ev0}) begin errors++; $display("FAIL rand_iss_valid cyc %0d got %b want %b", cyc, iss_valid, {ev1, ev0}); end
            if (ev0) begin
                checks++; if (iss_pkt[0] !== view[ix0]) begin errors++; $display("FAIL rand_pkt0 cyc %0d got %h want %h", cyc, iss_pkt[0], view[ix0]); end
            end
            if (ev1) begin
                checks++; if (iss_pkt[1] !== view[ix1]) begin errors++; $display("FAIL rand_pkt1 cyc %0d got %h want %h", cyc, iss_pkt[1], view[ix1]); end
            end

            for (int i = 0; i < N; i++) begin
                nb[i]  = m_busy[i];
                nxt[i] = m_busy[i] ? m_wake_pkt(m_pkt[i]) : m_pkt[i];
            end
            if (ev0) nb[ix0] = 1'b0;
            if (ev1) nb[ix1] = 1'b0;
            if (!flush && nfree >= 2) begin
                if (disp_valid[0]) begin
                    for (int i = 0; i < N; i++) begin
                        if (!m_busy[i]) begin
                            nb[i] = 1'b1; nxt[i] = m_wake_pkt(disp_pkt[0]);
                            break;
                        end
                    end
                end
                if (disp_valid[1]) begin
                    for (int i = N - 1; i >= 0; i--) begin
                        if (!m_busy[i]) begin
                            nb[i] = 1'b1; nxt[i] = m_wake_pkt(disp_pkt[1]);
                            break;
                        end
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                m_busy[i] = flush ? 1'b0 : nb[i];
                m_pkt[i]  = nxt[i];
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_dual_dispatch();
        test_stall();
        test_wakeup();
        test_dispatch_capture();
        test_flush();
        test_port_independence();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
